// File: rtl/sevenseg_pkg.sv
// ============================================================================
//  Module      : sevenseg_pkg
//  Description : Shared 7-segment definitions: segment order, hex pattern
//                table, capture FSM states and pattern-to-nibble decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sevenseg_pkg;

    // Segment bit positions within a GFE_DCBA pattern; DP sits just above G.
    localparam int c_seg_a  = 0;
    localparam int c_seg_g  = 6;
    localparam int c_seg_dp = c_seg_g + 1;

    localparam logic [6:0] c_blank_pattern = 7'h00;

    localparam logic [6:0] c_seg_table [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Returns {hit, nibble}; hit is 0 when the pattern is not a hex glyph.
    function automatic logic [4:0] seg_to_nibble(input logic [6:0] pattern);
        logic [4:0] result;
        result = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == c_seg_table[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Width-parameterised two-flop synchroniser, async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/sevenseg_capture.sv
// ============================================================================
//  Module      : sevenseg_capture
//  Description : Samples a multiplexed 7-segment bus, waits for a stable
//                window, decodes each digit back to hex and flags bad glyphs.
//                Optional decimal-point capture: define SEVENSEG_CAP_DP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
`ifdef SEVENSEG_CAP_DP_EN
    input  logic [c_seg_dp:0]       seg_i,
`else
    input  logic [c_seg_dp-1:0]     seg_i,
`endif
    input  logic [NUM_DIGITS-1:0]   dig_en_i,
    input  logic                    clear_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   digit_valid_o,
    output logic [NUM_DIGITS-1:0]   err_o,
`ifdef SEVENSEG_CAP_DP_EN
    output logic [NUM_DIGITS-1:0]   dp_o,
`endif
    output logic                    frame_done_o
);

`ifdef SEVENSEG_CAP_DP_EN
    localparam int SEG_W = c_seg_dp + 1;
`else
    localparam int SEG_W = c_seg_dp;
`endif
    localparam int S_W   = SEG_W + NUM_DIGITS;
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    // The capture edge is the one that moves the counter onto STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] c_cnt_pre_capture = CNT_W'(STABLE_CYCLES - 2);

    logic [S_W-1:0]          w_sync;
    logic [S_W-1:0]          w_sample;
    logic [S_W-1:0]          r_sample_prev;
    logic [SEG_W-1:0]        w_seg;
    logic [NUM_DIGITS-1:0]   w_dig;
    logic                    w_changed;
    logic                    w_onehot;
    logic                    w_capture;
    logic                    w_blank;
    logic [4:0]              w_decoded;
    logic [NUM_DIGITS-1:0]   w_mask_next;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic [NUM_DIGITS-1:0]   r_err;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic                    r_frame_done;
`ifdef SEVENSEG_CAP_DP_EN
    logic [NUM_DIGITS-1:0]   r_dp;
`endif

    sync_2ff #(
        .WIDTH (S_W)
    ) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     ({seg_i, dig_en_i}),
        .q     (w_sync)
    );

    assign w_sample  = SEG_ACTIVE_LOW ? ~w_sync : w_sync;
    assign w_seg     = w_sample[S_W-1 -: SEG_W];
    assign w_dig     = w_sample[NUM_DIGITS-1:0];
    assign w_changed = (w_sample != r_sample_prev);
    assign w_onehot  = (w_dig != '0) && ((w_dig & (w_dig - NUM_DIGITS'(1))) == '0);
    assign w_decoded = seg_to_nibble(w_seg[c_seg_g:c_seg_a]);
    assign w_blank   = (w_seg[c_seg_g:c_seg_a] == c_blank_pattern);
    assign w_capture = (r_state == SETTLE) && !w_changed && (r_cnt == c_cnt_pre_capture);
    assign w_mask_next = r_mask | w_dig;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= BLANK;
            r_cnt         <= '0;
            r_sample_prev <= '0;
        end else begin
            r_sample_prev <= w_sample;
            case (r_state)
                BLANK: begin
                    r_cnt <= '0;
                    if (w_onehot) begin
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_changed) begin
                        r_cnt   <= '0;
                        r_state <= w_onehot ? SETTLE : BLANK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_cnt_pre_capture) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_changed) begin
                        r_cnt   <= '0;
                        r_state <= w_onehot ? SETTLE : BLANK;
                    end
                end
                default: begin
                    r_state <= BLANK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle capture; the FSM keeps running regardless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_digits     <= '0;
            r_valid      <= '0;
            r_err        <= '0;
            r_mask       <= '0;
            r_frame_done <= 1'b0;
`ifdef SEVENSEG_CAP_DP_EN
            r_dp         <= '0;
`endif
        end else if (clear_i) begin
            r_digits     <= '0;
            r_valid      <= '0;
            r_err        <= '0;
            r_mask       <= '0;
            r_frame_done <= 1'b0;
`ifdef SEVENSEG_CAP_DP_EN
            r_dp         <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            if (w_capture) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (w_dig[k]) begin
                        if (w_decoded[4]) begin
                            r_digits[4*k +: 4] <= w_decoded[3:0];
                            r_valid[k]         <= 1'b1;
                        end else if (w_blank) begin
                            r_valid[k] <= 1'b0;
                        end else begin
                            r_err[k] <= 1'b1;
                        end
`ifdef SEVENSEG_CAP_DP_EN
                        r_dp[k] <= w_seg[c_seg_dp];
`endif
                    end
                end
                if (&w_mask_next) begin
                    r_frame_done <= 1'b1;
                    r_mask       <= '0;
                end else begin
                    r_mask <= w_mask_next;
                end
            end
        end
    end

    assign digits_o      = r_digits;
    assign digit_valid_o = r_valid;
    assign err_o         = r_err;
    assign frame_done_o  = r_frame_done;
`ifdef SEVENSEG_CAP_DP_EN
    assign dp_o          = r_dp;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
// ============================================================================
//  Module      : tb_sevenseg_capture
//  Description : Directed and randomised bench for sevenseg_capture with a
//                run-length reference model of the capture rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sevenseg_capture;

    localparam int NUM_DIGITS     = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam bit SEG_ACTIVE_LOW = 1'b1;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clear  = 1'b0;
    logic [6:0] seg    = 7'h7F;
    logic [3:0] dig_en = 4'hF;

    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        frame_done;

`ifdef SEVENSEG_CAP_DP_EN
    logic [7:0]  seg_bus;
    logic [3:0]  dp;
    assign seg_bus = {SEG_ACTIVE_LOW, seg};
`else
    logic [6:0]  seg_bus;
    assign seg_bus = seg;
`endif

    int checks       = 0;
    int failures     = 0;
    int frame_pulses = 0;

    logic [6:0] tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    sevenseg_capture #(
        .NUM_DIGITS     (NUM_DIGITS),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .seg_i         (seg_bus),
        .dig_en_i      (dig_en),
        .clear_i       (clear),
        .digits_o      (digits),
        .digit_valid_o (valid),
        .err_o         (err),
`ifdef SEVENSEG_CAP_DP_EN
        .dp_o          (dp),
`endif
        .frame_done_o  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] p);
        int n;
        n = -1;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == p) n = i;
        end
        return n;
    endfunction

    // Reference model: a digit is captured on the edge where the same one-hot
    // sample has been seen for exactly STABLE_CYCLES consecutive edges.
    logic [10:0] m_sync1, m_sync2, m_last;
    int          m_run;
    logic [15:0] m_digits;
    logic [3:0]  m_valid, m_err, m_mask;
    logic        m_frame;

    always @(posedge clk or negedge rst_n) begin : model_step
        logic [10:0] cur;
        logic [6:0]  s;
        logic [3:0]  d;
        int          k, n;
        if (!rst_n) begin
            m_sync1 = '0; m_sync2 = '0; m_last = '0; m_run = 0;
            m_digits = '0; m_valid = '0; m_err = '0; m_mask = '0; m_frame = 1'b0;
        end else begin
            cur = SEG_ACTIVE_LOW ? ~m_sync2 : m_sync2;
            if (m_run != 0 && cur == m_last) m_run++;
            else m_run = 1;
            m_last  = cur;
            s       = cur[10:4];
            d       = cur[3:0];
            m_frame = 1'b0;
            if (clear) begin
                m_digits = '0; m_valid = '0; m_err = '0; m_mask = '0;
            end else if ($countones(d) == 1 && m_run == STABLE_CYCLES) begin
                k = 0;
                for (int i = 0; i < 4; i++) if (d[i]) k = i;
                n = decode(s);
                if (n >= 0) begin
                    m_digits[4*k +: 4] = 4'(n);
                    m_valid[k] = 1'b1;
                end else if (s == 7'h00) begin
                    m_valid[k] = 1'b0;
                end else begin
                    m_err[k] = 1'b1;
                end
                m_mask[k] = 1'b1;
                if (&m_mask) begin
                    m_frame = 1'b1;
                    m_mask  = '0;
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = {seg_bus[6:0], dig_en};
        end
    end

    always @(negedge clk) begin
        check("digits", 32'(digits), 32'(m_digits));
        check("valid", 32'(valid), 32'(m_valid));
        check("err", 32'(err), 32'(m_err));
        check("frame_done", 32'(frame_done), 32'(m_frame));
        if (frame_done) frame_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [6:0] pat, input logic [3:0] dig);
        seg    = SEG_ACTIVE_LOW ? ~pat : pat;
        dig_en = SEG_ACTIVE_LOW ? ~dig : dig;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fp0;
        logic [3:0] rd;
        logic [6:0] rp;
        int hold;

        // Digit 0 shows "2" from release; capture lands on edge 10.
        drive(7'h5B, 4'b0001);
        tick(3);
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        rst_n = 1'b1;
        tick(9);
        check("t1_edge9_valid", 32'(valid), 32'h0);
        tick(1);
        check("t1_digit0", 32'(digits[3:0]), 32'h2);
        check("t1_valid", 32'(valid), 32'b0001);
        check("t1_err", 32'(err), 32'h0);
        check("t1_model_digit0", 32'(m_digits[3:0]), 32'h2);

        pulse_clear();
        fp0 = frame_pulses;
        drive(7'h06, 4'b0001); tick(20);
        drive(7'h5B, 4'b0010); tick(20);
        drive(7'h4F, 4'b0100); tick(20);
        drive(7'h66, 4'b1000); tick(20);
        check("scan_digits", 32'(digits), 32'h4321);
        check("scan_valid", 32'(valid), 32'hF);
        check("scan_one_frame", 32'(frame_pulses - fp0), 32'd1);
        tick(30);
        check("scan_no_second_frame", 32'(frame_pulses - fp0), 32'd1);

        for (int i = 0; i < 12; i++) begin
            drive((i % 2 == 1) ? 7'h06 : 7'h4F, 4'b0010);
            tick(5);
        end
        check("glitch_digits", 32'(digits), 32'h4321);
        check("glitch_valid", 32'(valid), 32'hF);
        check("glitch_frames", 32'(frame_pulses - fp0), 32'd1);

        drive(7'h49, 4'b0100); tick(20);
        check("bad_err", 32'(err), 32'b0100);
        check("bad_digits", 32'(digits), 32'h4321);
        drive(7'h07, 4'b0100); tick(20);
        check("sticky_err", 32'(err), 32'b0100);
        check("sticky_digits", 32'(digits), 32'h4721);
        pulse_clear();
        check("clear_digits", 32'(digits), 32'h0);
        check("clear_valid", 32'(valid), 32'h0);
        check("clear_err", 32'(err), 32'h0);

        drive(7'h06, 4'b0011); tick(50);
        drive(7'h06, 4'b0000); tick(50);
        check("multi_none_digits", 32'(digits), 32'h0);
        check("multi_none_valid", 32'(valid), 32'h0);
        drive(7'h6D, 4'b0001); tick(20);
        check("five_valid", 32'(valid), 32'b0001);
        drive(7'h00, 4'b0001); tick(20);
        check("blank_valid", 32'(valid), 32'h0);
        check("blank_err", 32'(err), 32'h0);
        check("blank_digits", 32'(digits), 32'h0005);

        drive(7'h39, 4'b1000); tick(20);
        check("pre_reset_valid", 32'(valid), 32'b1001 & 32'b1000);
        drive(7'h77, 4'b0001); tick(8);
        rst_n = 1'b0;
        #1;
        check("midreset_digits", 32'(digits), 32'h0);
        check("midreset_valid", 32'(valid), 32'h0);
        check("midreset_frame", 32'(frame_done), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(9);
        check("postreset_edge9_valid", 32'(valid), 32'h0);
        tick(1);
        check("postreset_valid", 32'(valid), 32'b0001);
        check("postreset_digits", 32'(digits), 32'h000A);

        for (int i = 0; i < 160; i++) begin
            hold = $urandom_range(2, 25);
            case ($urandom_range(0, 9))
                8:       rd = 4'b0000;
                9:       rd = 4'($urandom_range(0, 15));
                default: rd = 4'b0001 << $urandom_range(0, 3);
            endcase
            case ($urandom_range(0, 9))
                7:       rp = 7'h00;
                8, 9:    rp = 7'($urandom_range(0, 127));
                default: rp = tbl[$urandom_range(0, 15)];
            endcase
            drive(rp, rd);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) begin
                pulse_clear();
                tick(hold - 1);
            end else begin
                tick(hold);
            end
        end

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
